mcu_seq: RTL and testbench
==========================

Name: mcu_seq

Overview:
- Next-generation parametrised micro control unit: an ALU plus register-file memory behind a valid/ready command port and a pulsed response port.
- Adds what the single-cycle mcu lacks: a hardware memory-clear sequence after reset, a multi-cycle serial divider, divide-by-zero and illegal-opcode errors, and an explicit result strobe.
- Sits between a command sequencer or bus bridge and the datapath. One command in flight at a time.

Parameters:
- DATA_W, 32, operand/result/memory word width (>=2)
- ADDR_W, 10, memory address width; depth = 2**ADDR_W words

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  4  opcode
- cmd_src1  in  ADDR_W  address of operand A
- cmd_imm  in  DATA_W  LOAD data; bits [ADDR_W-1:0] are the address of operand B for ALU ops
- cmd_dst  in  ADDR_W  write-back address
- rsp_valid  out  1  one-cycle result strobe
- rsp_data  out  DATA_W  result; holds until the next strobe
- rsp_err  out  1  error flag for the current response; holds with rsp_data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (low DATA_W bits), 3 DIV (unsigned quotient), 4 AND, 5 OR, 6 XOR
  - 7 READ: rsp_data = mem[src1], no write
  - 8 LOAD: mem[dst] = cmd_imm
  - 9-15 illegal
- All arithmetic is unsigned, DATA_W bits, wrap-around; no overflow flag.
- States: INIT, IDLE, EXEC, DIV.
- reset==0 at a clock edge:
  - state <= INIT, clear counter <= 0
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, cmd_ready = 0, busy = 1
  - any in-flight command is aborted with no write and no response.
- INIT:
  - one word per cycle, mem[cnt] <= 0, then cnt++.
  - After writing address 2**ADDR_W-1, go to IDLE.
  - cmd_ready first rises exactly 2**ADDR_W cycles after reset returns high.
- IDLE:
  - cmd_ready = 1.
  - Accept on cmd_valid && cmd_ready.
  - At acceptance, capture A = mem[src1], B = mem[imm[ADDR_W-1:0]], op, dst, imm.
  - Then go to DIV if op==3 and B!=0, else EXEC.
- EXEC (one cycle):
  - Write mem[dst] for ops 0-2, 4-6 and 8.
  - Assert rsp_valid, then return to IDLE.
  - rsp_valid is therefore 1 cycle after acceptance; peak throughput is 1 command per 2 cycles.
  - Illegal op: rsp_err = 1, rsp_data = 0, no write.
  - DIV with B==0: rsp_err = 1, rsp_data = all ones, no write.
  - All other ops: rsp_err = 0.
- DIV:
  - Restoring division, one quotient bit per cycle, DATA_W cycles.
  - Then write mem[dst] = quotient, rsp_valid = 1, rsp_data = quotient, rsp_err = 0, return to IDLE.
  - Latency from acceptance to rsp_valid = DATA_W+1 cycles.
- cmd_ready is 0 in INIT, EXEC and DIV. cmd_valid in those states is ignored, not queued.
- No response backpressure; rsp_valid is a single-cycle pulse.
- Operands are captured at acceptance, so dst == src1 or dst == src2 is safe.
- A command accepted in the cycle after a write-back sees the new value. The memory write port is used only by INIT and the final cycle of EXEC/DIV, so the two never conflict.
- Memory reads are asynchronous.

Decomposition:
- Package mcu_pkg:
  - opcode constants (OP_ADD..OP_LOAD, OP_W = 4)
  - state encoding (ST_INIT, ST_IDLE, ST_EXEC, ST_DIV)
- Sub-module mcu_div_serial(clk, reset, start, dividend, divisor, done, quotient):
  - parametrised by DATA_W
  - done pulses DATA_W cycles after start
  - reset aborts it
- The ALU for ops 0-2 and 4-6 stays combinational inside mcu_seq.

Test Plan:
1. ADDR_W=4. Hold reset low 2 cycles, release -> cmd_ready=0 for exactly 16 cycles, then 1; READ src1=5 -> rsp_data=0, rsp_err=0 one cycle after accept.
2. LOAD dst=3 imm=0x1234; LOAD dst=4 imm=0x10; ADD src1=3 imm=4 dst=5 -> rsp_data=0x1244 one cycle after accept; READ src1=5 -> 0x1244; SUB 4-3 -> 0xFFFFEDDC.
3. mem[1]=100, mem[2]=7, DIV src1=1 imm=2 dst=6 -> cmd_ready low throughout, rsp_valid exactly 33 cycles after accept with data 14; READ 6 -> 14; cmd_valid held during DIV is not accepted.
4. DIV by mem[0]=0, dst=6 -> rsp_err=1, rsp_data=0xFFFFFFFF after 1 cycle; mem[6] unchanged; MUL 0x10000*0x10000 -> 0.
5. cmd_op=9 with dst=3 -> rsp_err=1, rsp_data=0, mem[3] unchanged; next ADD -> rsp_err=0.
6. Assert reset 10 cycles into a DIV -> no rsp_valid, outputs zero, INIT reruns; after INIT, READ dst -> 0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared opcode and state definitions for the mcu_seq control unit.
package mcu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
  localparam logic [OP_W-1:0] OP_AND  = 4'd4;
  localparam logic [OP_W-1:0] OP_OR   = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
  localparam logic [OP_W-1:0] OP_READ = 4'd7;
  localparam logic [OP_W-1:0] OP_LOAD = 4'd8;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EXEC,
    ST_DIV
  } state_t;

endpackage

// File: rtl/mcu_div_serial.sv
// Unsigned restoring divider: one quotient bit per clock, done pulses DATA_W cycles after start.
module mcu_div_serial #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   rem_sub;

  // The dividend shifts out of quo_q into the remainder while quotient bits shift in.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    rem_sh  = {rem_q, quo_q[DATA_W-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (!rem_sub[DATA_W]) begin
        rem_d = rem_sub[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DATA_W-1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/mcu_seq.sv
// Micro control unit: ALU and register-file memory behind a valid/ready command port,
// with a post-reset memory clear and a serial divider.
module mcu_seq
  import mcu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_a, rd_b, alu_res, div_quot;
  logic              accept, div_start, div_done, alu_wr, alu_err;

  assign rd_a      = mem[cmd_src1];
  assign rd_b      = mem[cmd_imm[ADDR_W-1:0]];
  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign div_start = accept && (cmd_op == OP_DIV) && (rd_b != '0);

  mcu_div_serial #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (rd_a),
    .divisor  (rd_b),
    .done     (div_done),
    .quotient (div_quot)
  );

  // A DIV only reaches EXEC when its divisor was zero.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    alu_wr  = 1'b0;
    case (op_q)
      OP_ADD:  begin alu_res = a_q + b_q; alu_wr = 1'b1; end
      OP_SUB:  begin alu_res = a_q - b_q; alu_wr = 1'b1; end
      OP_MUL:  begin alu_res = a_q * b_q; alu_wr = 1'b1; end
      OP_AND:  begin alu_res = a_q & b_q; alu_wr = 1'b1; end
      OP_OR:   begin alu_res = a_q | b_q; alu_wr = 1'b1; end
      OP_XOR:  begin alu_res = a_q ^ b_q; alu_wr = 1'b1; end
      OP_DIV:  begin alu_res = '1; alu_err = 1'b1; end
      OP_READ: alu_res = a_q;
      OP_LOAD: begin alu_res = imm_q; alu_wr = 1'b1; end
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    op_d        = op_q;
    dst_d       = dst_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    mem_waddr   = cnt_q;
    mem_wdata   = '0;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (&cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          a_d     = rd_a;
          b_d     = rd_b;
          imm_d   = cmd_imm;
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          state_d = div_start ? ST_DIV : ST_EXEC;
        end
      end
      ST_EXEC: begin
        mem_we      = alu_wr;
        mem_waddr   = dst_q;
        mem_wdata   = alu_res;
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_res;
        rsp_err_d   = alu_err;
        state_d     = ST_IDLE;
      end
      ST_DIV: begin
        if (div_done) begin
          mem_we      = 1'b1;
          mem_waddr   = dst_q;
          mem_wdata   = div_quot;
          rsp_valid_d = 1'b1;
          rsp_data_d  = div_quot;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      op_q        <= '0;
      dst_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Writes are suppressed while reset is low so an aborted command leaves memory untouched.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mcu_seq.sv
// Scoreboard bench for mcu_seq: expected responses come from a behavioural memory/ALU model.
module tb_mcu_seq;
  import mcu_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_src1;
  logic [DATA_W-1:0] cmd_imm;
  logic [ADDR_W-1:0] cmd_dst;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  always #5 clk = ~clk;

  mcu_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src1  (cmd_src1),
    .cmd_imm   (cmd_imm),
    .cmd_dst   (cmd_dst),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  int                err_cnt = 0;
  int                chk_cnt = 0;
  logic [DATA_W:0]   sb_q[$];
  logic [DATA_W:0]   sb_exp;
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] last_data;
  logic              last_err;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W:0] model_exec(input logic [OP_W-1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] imm);
    case (op)
      OP_ADD:  return {1'b0, a + b};
      OP_SUB:  return {1'b0, a - b};
      OP_MUL:  return {1'b0, a * b};
      OP_DIV:  return (b == '0) ? {1'b1, {DATA_W{1'b1}}} : {1'b0, a / b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_READ: return {1'b0, a};
      OP_LOAD: return {1'b0, imm};
      default: return {1'b1, {DATA_W{1'b0}}};
    endcase
  endfunction

  // Every response pops one expectation; a response with nothing queued is an error.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        sb_exp = sb_q.pop_front();
        checkOutput("rsp_data", rsp_data, sb_exp[DATA_W-1:0]);
        checkOutput("rsp_err", rsp_err, sb_exp[DATA_W]);
        last_data = rsp_data;
        last_err  = rsp_err;
      end
    end
  end

  task automatic doReset();
    int n;
    @(negedge clk);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", rsp_valid, 1'b0);
    checkOutput("rst_data", rsp_data, '0);
    checkOutput("rst_err", rsp_err, 1'b0);
    checkOutput("rst_ready", cmd_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (cmd_ready === 1'b1) break;
    end
    checkOutput("init_cycles", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic applyStimulus(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] src1,
                               input logic [DATA_W-1:0] imm, input logic [ADDR_W-1:0] dst,
                               input bit hold_junk, input bit abort);
    logic [DATA_W-1:0] a, b;
    logic [DATA_W:0]   e;
    int                n, lat, exp_lat, ready_seen;
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checkOutput("ready_wait", cmd_ready, 1'b1);
      return;
    end
    a       = model_mem[src1];
    b       = model_mem[imm[ADDR_W-1:0]];
    e       = model_exec(op, a, b, imm);
    exp_lat = (op == OP_DIV && b != '0) ? DATA_W + 1 : 1;
    if (!abort) begin
      sb_q.push_back(e);
      if (op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_LOAD} ||
          (op == OP_DIV && b != '0))
        model_mem[dst] = e[DATA_W-1:0];
    end
    cmd_op    = op;
    cmd_src1  = src1;
    cmd_imm   = imm;
    cmd_dst   = dst;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold_junk) begin
      cmd_op  = OP_LOAD;
      cmd_dst = 4'd7;
      cmd_imm = 32'h0000DEAD;
    end else begin
      cmd_valid = 1'b0;
    end
    if (abort) return;
    lat        = 0;
    ready_seen = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid === 1'b1) break;
      if (cmd_ready === 1'b1) ready_seen++;
    end
    cmd_valid = 1'b0;
    checkOutput("latency", lat, exp_lat);
    checkOutput("ready_low_in_flight", ready_seen, 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [OP_W-1:0]   rop;
    logic [ADDR_W-1:0] rs, rd;
    logic [DATA_W-1:0] ri;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_src1  = '0;
    cmd_imm   = '0;
    cmd_dst   = '0;
    last_data = '0;
    last_err  = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    doReset();
    applyStimulus(OP_READ, 4'd5, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("t1_read_zero", last_data, 32'd0);

    applyStimulus(OP_LOAD, 4'd0, 32'h1234, 4'd3, 1'b0, 1'b0);
    applyStimulus(OP_LOAD, 4'd0, 32'h10, 4'd4, 1'b0, 1'b0);
    applyStimulus(OP_ADD, 4'd3, 32'd4, 4'd5, 1'b0, 1'b0);
    checkOutput("t2_add", last_data, 32'h1244);
    applyStimulus(OP_READ, 4'd5, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("t2_read_back", last_data, 32'h1244);
    applyStimulus(OP_SUB, 4'd4, 32'd3, 4'd8, 1'b0, 1'b0);
    checkOutput("t2_sub_wrap", last_data, 32'hFFFFEDDC);

    applyStimulus(OP_LOAD, 4'd0, 32'd100, 4'd1, 1'b0, 1'b0);
    applyStimulus(OP_LOAD, 4'd0, 32'd7, 4'd2, 1'b0, 1'b0);
    applyStimulus(OP_DIV, 4'd1, 32'd2, 4'd6, 1'b1, 1'b0);
    checkOutput("t3_div", last_data, 32'd14);
    applyStimulus(OP_READ, 4'd6, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("t3_read_quot", last_data, 32'd14);
    applyStimulus(OP_READ, 4'd7, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("t3_junk_ignored", last_data, 32'd0);

    applyStimulus(OP_DIV, 4'd1, 32'd0, 4'd6, 1'b0, 1'b0);
    checkOutput("t4_div0_data", last_data, 32'hFFFFFFFF);
    checkOutput("t4_div0_err", last_err, 1'b1);
    applyStimulus(OP_READ, 4'd6, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("t4_dst_kept", last_data, 32'd14);
    applyStimulus(OP_LOAD, 4'd0, 32'h10000, 4'd9, 1'b0, 1'b0);
    applyStimulus(OP_MUL, 4'd9, 32'd9, 4'd10, 1'b0, 1'b0);
    checkOutput("t4_mul_wrap", last_data, 32'd0);

    applyStimulus(4'd9, 4'd1, 32'd2, 4'd3, 1'b0, 1'b0);
    checkOutput("t5_illegal_err", last_err, 1'b1);
    applyStimulus(OP_READ, 4'd3, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("t5_dst_kept", last_data, 32'h1234);
    applyStimulus(OP_ADD, 4'd3, 32'd4, 4'd11, 1'b0, 1'b0);
    checkOutput("t5_err_cleared", last_err, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rop = OP_W'($urandom_range(0, 10));
      rs  = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd  = ADDR_W'($urandom_range(0, DEPTH - 1));
      ri  = $urandom;
      if (i < 6) rop = OP_LOAD;
      applyStimulus(rop, rs, ri, rd, 1'b0, 1'b0);
    end

    applyStimulus(OP_LOAD, 4'd0, 32'd100, 4'd1, 1'b0, 1'b0);
    applyStimulus(OP_LOAD, 4'd0, 32'd7, 4'd2, 1'b0, 1'b0);
    applyStimulus(OP_DIV, 4'd1, 32'd2, 4'd6, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    doReset();
    applyStimulus(OP_READ, 4'd6, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("t6_dst_cleared", last_data, 32'd0);
    applyStimulus(OP_READ, 4'd1, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("t6_mem_cleared", last_data, 32'd0);

    repeat (3) @(posedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
